// File: rtl/q2_outport_if.sv
// CPU-side bus and serial status signals of the q2 output port.
// dbus is bidirectional and stays a plain port on the block itself.
interface q2_outport_if;
    logic [11:0] abus;
    logic        wrm;
    logic        rdm;
    logic        io_sel;
    logic        tx;
    logic        busy;

    modport master (
        output abus,
        output wrm,
        output rdm,
        input  io_sel,
        input  tx,
        input  busy
    );

    modport slave (
        input  abus,
        input  wrm,
        input  rdm,
        output io_sel,
        output tx,
        output busy
    );
endinterface

// File: rtl/q2_outport.sv
// Memory-mapped serial output port.
// Writes to 0xFFF queue a 12-bit word.
// Writes to 0xFFE clear the overflow flag.
// Reads of 0xFFE return the status word.
// Queued words leave on tx as start bit, 12 data bits LSB first and a stop bit.
module q2_outport #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DEPTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    q2_outport_if.slave      bus,
    inout  wire  [11:0]      dbus
);

    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam logic [11:0] AddrStat = 12'hFFE;
    localparam logic [11:0] AddrData = 12'hFFF;
    localparam logic [7:0]  BaudMax  = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  CntFull  = 5'(DEPTH);
    localparam logic [3:0]  LastBit  = 4'd11;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Reset synchronizer: assertion is immediate, release is aligned to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Reset synchronizer shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Write strobe edge detection.
    // arm_q blocks a strobe that was already high when reset released.
    logic wrm_q;
    logic arm_q;
    logic wr_ev;
    logic push_req;
    logic clr_req;

    assign wr_ev    = bus.wrm & ~wrm_q & arm_q;
    assign push_req = wr_ev & (bus.abus == AddrData);
    assign clr_req  = wr_ev & (bus.abus == AddrStat);

    // Strobe history registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wrm_q <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            wrm_q <= bus.wrm;
            arm_q <= arm_q | ~bus.wrm;
        end
    end

    // FIFO storage and bookkeeping.
    logic [11:0]     mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;

    tx_state_e       state_q, state_d;

    assign fifo_empty = (cnt_q == 5'd0);
    assign fifo_full  = (cnt_q == CntFull);
    assign pop        = (state_q == StIdle) & ~fifo_empty;
    // A pop on the same edge frees the slot the push needs.
    assign push       = push_req & (~fifo_full | pop);

    // FIFO pointer, count and overflow next-state.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (push) begin
            tail_d = tail_q + PtrW'(1);
        end
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 5'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 5'd1;
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (clr_req) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 5'd0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // FIFO data array write.
    // The array has no reset; the count qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= dbus;
        end
    end

    // Transmitter.
    logic [7:0]  baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [11:0] shreg_q, shreg_d;
    logic        tx_q, tx_d;

    // Transmitter next-state.
    // tx_d is the line level for the cycle that follows.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = StStart;
                    baud_d  = 8'd0;
                    shreg_d = mem_q[head_q];
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_q == BaudMax) begin
                    state_d = StData;
                    baud_d  = 8'd0;
                    bit_d   = 4'd0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 8'd1;
                    tx_d   = 1'b0;
                end
            end
            StData: begin
                if (baud_q == BaudMax) begin
                    baud_d = 8'd0;
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {1'b0, shreg_q[11:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (baud_q == BaudMax) begin
                    state_d = StIdle;
                    baud_d  = 8'd0;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmitter state registers.
    // tx is forced high directly by reset.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
            baud_q  <= 8'd0;
            bit_q   <= 4'd0;
            shreg_q <= 12'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Bus-facing outputs.
    logic [11:0] status;
    logic        stat_rd;

    assign status = {fifo_full, fifo_empty, (state_q != StIdle), ovf_q, 3'b000, cnt_q};
    assign stat_rd = bus.rdm & (bus.abus == AddrStat);

    assign dbus       = stat_rd ? status : {12{1'bz}};
    assign bus.io_sel = (bus.abus == AddrStat) | (bus.abus == AddrData);
    assign bus.tx     = tx_q;
    assign bus.busy   = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_q2_outport.sv
// Directed plus randomized bench for q2_outport.
// A tx-line receiver collects frames.
// The received frames are compared with the queue of words the bench expects to be sent.
module tb_q2_outport;

    localparam int CPB   = 4;
    localparam int DEP   = 8;
    localparam int FRAME = 14 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    wire  [11:0] dbus;
    logic        tb_oe = 1'b0;
    logic [11:0] tb_val = 12'h000;

    q2_outport_if bus ();

    assign dbus = tb_oe ? tb_val : {12{1'bz}};

    q2_outport #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dbus(dbus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [11:0] exp_q[$];
    logic [11:0] rx_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write with a strobe held for len cycles, then low for gap cycles.
    task automatic write_w(input logic [11:0] a, input logic [11:0] d, input int len,
                           input int gap);
        bus.abus = a;
        tb_val   = d;
        tb_oe    = 1'b1;
        bus.wrm  = 1'b1;
        repeat (len) @(negedge clk);
        bus.wrm  = 1'b0;
        tb_oe    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push_w(input logic [11:0] d, input int len, input int gap);
        write_w(12'hFFF, d, len, gap);
        exp_q.push_back(d);
    endtask

    task automatic rd_status(output logic [11:0] v);
        bus.abus = 12'hFFE;
        bus.rdm  = 1'b1;
        tb_oe    = 1'b0;
        #1;
        v = dbus;
        @(negedge clk);
        bus.rdm  = 1'b0;
        bus.abus = 12'h000;
    endtask

    // The bench drives a probe value; a block that stays off the bus leaves it intact.
    task automatic rd_other(input logic [11:0] a, output logic [11:0] v, output logic sel);
        bus.abus = a;
        bus.rdm  = 1'b1;
        tb_val   = 12'hA5A;
        tb_oe    = 1'b1;
        #1;
        v   = dbus;
        sel = bus.io_sel;
        @(negedge clk);
        bus.rdm  = 1'b0;
        tb_oe    = 1'b0;
        bus.abus = 12'h000;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (bus.busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk(tag, 64'(rx_q[i]), 64'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Receiver: samples mid-bit after a falling edge; frames cut by reset are dropped.
    initial begin : rx_mon
        logic        tx_prev;
        logic        ab;
        logic [13:0] bits;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && tx_prev && !bus.tx) begin
                ab   = 1'b0;
                bits = '0;
                for (int n = 0; n < FRAME; n++) begin
                    if (n > 0) @(negedge clk);
                    if (!rst) ab = 1'b1;
                    if (n % CPB == CPB / 2) bits[n / CPB] = bus.tx;
                end
                if (!ab) begin
                    chk("frame_start_bit", 64'(bits[0]), 64'd0);
                    chk("frame_stop_bit", 64'(bits[13]), 64'd1);
                    rx_q.push_back(bits[12:1]);
                end
            end
            tx_prev = bus.tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [11:0] v;
        logic        s;
        logic [11:0] w;
        logic [63:0] obs;
        logic [63:0] expv;
        logic        bv;
        int          n;
        logic [11:0] a;

        bus.abus = 12'h000;
        bus.wrm  = 1'b0;
        bus.rdm  = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(bus.tx), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rd_status(v);
        chk("rst_status", 64'(v), 64'h400);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rd_status(v);
        chk("status_after_rst", 64'(v), 64'h400);
        rd_other(12'h123, v, s);
        chk("rd_123_dbus", 64'(v), 64'hA5A);
        chk("rd_123_io_sel", 64'(s), 64'd0);
        rd_other(12'hFFF, v, s);
        chk("rd_fff_dbus", 64'(v), 64'hA5A);
        chk("rd_fff_io_sel", 64'(s), 64'd1);

        // Exact line waveform of one frame
        w    = 12'h5A3;
        expv = '0;
        for (int j = 0; j < 14; j++) begin
            bv = (j == 0) ? 1'b0 : (j == 13) ? 1'b1 : w[j-1];
            for (int k = 0; k < CPB; k++) expv[j*CPB+k] = bv;
        end
        bus.abus = 12'hFFF;
        tb_val   = w;
        tb_oe    = 1'b1;
        bus.wrm  = 1'b1;
        @(negedge clk);
        bus.wrm  = 1'b0;
        tb_oe    = 1'b0;
        exp_q.push_back(w);
        chk("idle_gap_tx", 64'(bus.tx), 64'd1);
        chk("idle_gap_busy", 64'(bus.busy), 64'd1);
        obs = '0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            obs[i] = bus.tx;
        end
        chk("frame_5a3_wave", obs, expv);
        @(negedge clk);
        chk("post_frame_busy", 64'(bus.busy), 64'd0);
        chk("post_frame_tx", 64'(bus.tx), 64'd1);
        drain();
        check_rx("rx_5a3");

        // Long strobe pushes once
        push_w(12'h111, 1, 1);
        push_w(12'h0FF, 5, 1);
        rd_status(v);
        chk("long_strobe_status", 64'(v), 64'h201);
        drain();
        check_rx("rx_long_strobe");

        // Overflow while the transmitter is mid-frame
        push_w(12'h0AA, 1, 1);
        for (int i = 1; i <= 9; i++) begin
            if (i <= DEP) push_w(12'(i), 1, 1);
            else write_w(12'hFFF, 12'(i), 1, 1);
        end
        rd_status(v);
        chk("overflow_status", 64'(v), 64'hB08);
        write_w(12'hFFE, 12'hFFF, 1, 1);
        rd_status(v);
        chk("overflow_cleared_status", 64'(v), 64'hA08);
        drain();
        check_rx("rx_overflow");

        // Push into a full FIFO on the same edge as the idle pop
        push_w(12'h0C1, 1, 1);
        for (int i = 0; i < DEP; i++) push_w(12'h100 + 12'(i), 1, 1);
        repeat (FRAME - 2 * DEP) @(negedge clk);
        push_w(12'hDDD, 1, 1);
        rd_status(v);
        chk("full_push_pop_status", 64'(v), 64'hA08);
        drain();
        check_rx("rx_full_push_pop");

        // Random batches with unrelated bus traffic mixed in
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, DEP);
            for (int i = 0; i < n; i++) begin
                a = 12'($urandom_range(0, 4095));
                bus.abus = a;
                #1;
                chk("io_sel_rand", 64'(bus.io_sel), 64'((a == 12'hFFE) || (a == 12'hFFF)));
                @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    a = 12'($urandom_range(0, 12'hFFD));
                    write_w(a, 12'($urandom_range(0, 4095)), 1, 1);
                    rd_other(a, v, s);
                    chk("rand_other_dbus", 64'(v), 64'hA5A);
                    chk("rand_other_io_sel", 64'(s), 64'd0);
                end
                push_w(12'($urandom_range(0, 4095)), $urandom_range(1, 4), $urandom_range(1, 3));
            end
            drain();
            check_rx("rx_rand");
        end

        // Reset in the middle of data bit 6 with another word queued
        write_w(12'hFFF, 12'h3C5, 1, 1);
        write_w(12'hFFF, 12'h2B4, 1, 1);
        repeat (27) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midframe_rst_tx", 64'(bus.tx), 64'd1);
        chk("midframe_rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rd_status(v);
        chk("midframe_rst_status", 64'(v), 64'h400);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rd_status(v);
        chk("post_rst_status", 64'(v), 64'h400);
        repeat (3 * FRAME) @(negedge clk);
        check_rx("rx_no_residual");

        // Strobe held high across reset release
        rst      = 1'b0;
        bus.abus = 12'hFFF;
        tb_val   = 12'h777;
        tb_oe    = 1'b1;
        bus.wrm  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        bus.wrm = 1'b0;
        tb_oe   = 1'b0;
        @(negedge clk);
        rd_status(v);
        chk("held_wrm_status", 64'(v), 64'h400);
        push_w(12'h777, 1, 1);
        drain();
        check_rx("rx_after_held_wrm");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
